truth_table_capture: RTL
========================

Name: truth_table_capture

Overview:
- Hardware counterpart of an exhaustive stimulus bench: it sweeps every combination of an N-bit input vector into a combinational circuit under test (CUT) and samples the CUT's 1-bit response for each.
- It assembles the captured truth table, compares it against an expected table, and reports the result.
- Sits beside a lab CUT on the FPGA, replacing the simulation-only driver and monitor.

Parameters:
- N_IN, 3, width of the stimulus vector; table has 2^N_IN entries (N_IN 1..8).
- SETTLE, 2, settle cycles per vector before sampling (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep (sampled in IDLE or DONE only).
- stim  out  N_IN  vector driven to the CUT; stim[N_IN-1] is the MSB (first listed CUT input).
- resp  in  1  CUT output.
- expected  in  2^N_IN  golden table; bit i is the expected resp for stim == i.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high from sweep completion until the next accepted start.
- table_q  out  2^N_IN  captured table; bit i is resp sampled with stim == i.
- mismatch  out  1  valid when done is high; 1 if table_q != expected.
- err_cnt  out  N_IN+1  number of differing bits; valid when done is high.

Behaviour:
- One clock domain: clk, with asynchronous active-low reset rst_n.
- Reset (async assert, sync-released by the system) forces:
  - state=IDLE;
  - stim, table_q, err_cnt, idx, settle count = 0;
  - busy, done, mismatch = 0.
- Reset mid-sweep aborts immediately; no partial result is retained.
- States:
  - IDLE: start=1 → clear table_q, err_cnt, mismatch; idx=0, stim=0, settle count=SETTLE; go to RUN; busy=1, done=0 at the same edge.
  - RUN: stim always equals idx. Each vector lasts SETTLE+1 cycles: SETTLE waiting cycles, then a sample cycle. On the sample edge, table_q[idx] <= resp and err_cnt increments if resp != expected[idx]. If idx == 2^N_IN-1, go to CHECK; else idx+1 and reload the settle count.
  - CHECK: one cycle; mismatch <= (err_cnt != 0); go to DONE; busy=0, done=1.
  - DONE: outputs held stable; start=1 behaves exactly as start in IDLE.
- Latency: the start-accepting edge to the done-rising edge is 2^N_IN*(SETTLE+1)+1 cycles.
- With SETTLE=0, resp is sampled on the first edge of each vector.
- start while busy is ignored.
- start held high in DONE restarts every time the block returns to DONE; an accepted start needs no edge detection.
- stim wraps nowhere: idx never exceeds 2^N_IN-1.
- expected may change during a sweep; each bit is read only at its own sample edge.
- err_cnt saturates at 2^N_IN, so it never wraps (width N_IN+1 suffices).

Optional Feature:
- Macro: TRUTH_TABLE_CAPTURE_FIRST_FAIL_EN.
- When defined:
  - extra outputs first_fail (N_IN bits) and first_fail_vld (1).
  - On the first mismatching sample of a sweep, record idx into first_fail and set first_fail_vld.
  - Both clear on accepted start and on reset.
- When undefined: the ports are absent and no logic is generated; all other behaviour is identical.

Decomposition:
- Package truth_table_capture_pkg:
  - state encoding constants IDLE, RUN, CHECK, DONE (2 bits);
  - helper constant TBL_W = 2^N_IN expressed as a localparam function of N_IN.
- One natural sub-module, ttc_settle_timer: reloadable down-counter of width 4 with a terminal-count pulse. It provides the sample strobe to the FSM.

Test Plan:
1. Majority CUT (N_IN=3, SETTLE=2), expected=8'hE8, start pulsed 1 cycle → stim steps 0..7, each held 3 cycles; done rises 25 cycles after the start edge; table_q=8'hE8, mismatch=0, err_cnt=0.
2. Same CUT, expected=8'hE9 → table_q=8'hE8, mismatch=1, err_cnt=1; with FIRST_FAIL_EN: first_fail=0, first_fail_vld=1.
3. resp tied 0, expected=8'hFF → err_cnt=8 (saturation boundary), mismatch=1; with FIRST_FAIL_EN: first_fail=0.
4. SETTLE=0, CUT = stim[0] → stim changes every cycle; done 9 cycles after start; table_q=8'hAA.
5. Start pulsed at cycle 5 of a sweep → no effect; sweep completes normally. Then start in DONE → done drops at the same edge, table_q clears, new sweep gives an identical result.
6. rst_n asserted asynchronously mid-sweep (idx=4) → busy, stim, table_q, err_cnt immediately 0; no done after release until a new start.

Source files
------------

// File: rtl/truth_table_capture_pkg.sv
// Shared definitions for the truth-table capture block: FSM state encoding
// and the table-width helper.
package truth_table_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int tbl_w(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/ttc_settle_timer.sv
// Reloadable 4-bit down-counter; o_tc flags the sample cycle once the
// settle count has run out while enabled.
module ttc_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_en,
    input  logic [3:0] i_val,
    output logic       o_tc
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_en && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_tc = i_en && (r_cnt == 4'd0);

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps every N_IN-bit stimulus into a combinational CUT, captures its truth
// table and compares it with a golden table. Optional: TRUTH_TABLE_CAPTURE_FIRST_FAIL_EN.
module truth_table_capture
    import truth_table_capture_pkg::*;
#(
    parameter  int N_IN   = 3,
    parameter  int SETTLE = 2,
    localparam int TBL_W  = tbl_w(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  stim,
    input  logic             resp,
    input  logic [TBL_W-1:0] expected,
    output logic             busy,
    output logic             done,
    output logic [TBL_W-1:0] table_q,
    output logic             mismatch,
`ifdef TRUTH_TABLE_CAPTURE_FIRST_FAIL_EN
    output logic [N_IN-1:0]  first_fail,
    output logic             first_fail_vld,
`endif
    output logic [N_IN:0]    err_cnt
);

    state_t           r_state;
    logic [N_IN-1:0]  r_idx;
    logic [TBL_W-1:0] r_table;
    logic [N_IN:0]    r_err_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_mismatch;
    logic             w_tc;
    logic             w_last;
    logic             w_accept;
    logic             w_load;
    logic             w_bad;
`ifdef TRUTH_TABLE_CAPTURE_FIRST_FAIL_EN
    logic [N_IN-1:0]  r_first_fail;
    logic             r_first_fail_vld;
`endif

    function automatic logic [N_IN:0] sat_inc(input logic [N_IN:0] v);
        return (v == (N_IN+1)'(TBL_W)) ? v : v + {{N_IN{1'b0}}, 1'b1};
    endfunction

    assign w_last   = (r_idx == N_IN'(TBL_W - 1));
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_load   = w_accept || ((r_state == RUN) && w_tc && !w_last);
    assign w_bad    = (resp != expected[r_idx]);

    ttc_settle_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_en   (r_state == RUN),
        .i_val  (4'(SETTLE)),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_table    <= '0;
            r_err_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
`ifdef TRUTH_TABLE_CAPTURE_FIRST_FAIL_EN
            r_first_fail     <= '0;
            r_first_fail_vld <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= RUN;
                        r_idx      <= '0;
                        r_table    <= '0;
                        r_err_cnt  <= '0;
                        r_mismatch <= 1'b0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
`ifdef TRUTH_TABLE_CAPTURE_FIRST_FAIL_EN
                        r_first_fail     <= '0;
                        r_first_fail_vld <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (w_tc) begin
                        r_table[r_idx] <= resp;
                        if (w_bad) begin
                            r_err_cnt <= sat_inc(r_err_cnt);
`ifdef TRUTH_TABLE_CAPTURE_FIRST_FAIL_EN
                            if (!r_first_fail_vld) begin
                                r_first_fail     <= r_idx;
                                r_first_fail_vld <= 1'b1;
                            end
`endif
                        end
                        if (w_last) begin
                            r_state <= CHECK;
                        end else begin
                            r_idx <= r_idx + {{(N_IN-1){1'b0}}, 1'b1};
                        end
                    end
                end
                CHECK: begin
                    r_mismatch <= (r_err_cnt != '0);
                    r_state    <= DONE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stim     = r_idx;
    assign table_q  = r_table;
    assign err_cnt  = r_err_cnt;
    assign busy     = r_busy;
    assign done     = r_done;
    assign mismatch = r_mismatch;
`ifdef TRUTH_TABLE_CAPTURE_FIRST_FAIL_EN
    assign first_fail     = r_first_fail;
    assign first_fail_vld = r_first_fail_vld;
`endif

endmodule
